mfp_xadc_drp_reader: RTL and testbench

Producer side of the XADC result path. Watches the XADC primitive's end-of-conversion pulse and reads two channel registers over the DRP port. Packs the two 12-bit codes into one 24-bit `analog_result` word, `{resultB, resultA}`, which drives the AHB XADC read peripheral. Both halves update in the same cycle, so software never reads a mixed pair.

---
 rtl/mfp_xadc_drp_reader_if.sv | 31 +++
 rtl/mfp_xadc_drp_reader.sv | 195 +++++++++++++++++++
 tb/tb_mfp_xadc_drp_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_xadc_drp_reader_if.sv
// -----------------------------------------------------------------------------
// mfp_xadc_drp_reader_if
// DRP (dynamic reconfiguration port) bundle between the XADC result reader and
// the XADC primitive.
//   daddr   : 7-bit DRP address          (reader -> XADC)
//   den     : DRP enable, 1-cycle strobe (reader -> XADC)
//   dwe     : DRP write enable           (reader -> XADC)
//   di      : DRP write data             (reader -> XADC)
//   do_data : DRP read data, valid with drdy (XADC -> reader); the primitive's
//             pin is called DO, which is a reserved word in SystemVerilog
//   drdy    : DRP data ready, 1-cycle pulse  (XADC -> reader)
// Modports: master = reader side, slave = XADC / DRP model side.
// -----------------------------------------------------------------------------
interface mfp_xadc_drp_reader_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] do_data;
  logic        drdy;

  modport master (
    output daddr, den, dwe, di,
    input  do_data, drdy
  );

  modport slave (
    input  daddr, den, dwe, di,
    output do_data, drdy
  );
endinterface

// File: rtl/mfp_xadc_drp_reader.sv
// -----------------------------------------------------------------------------
// mfp_xadc_drp_reader
// Producer side of the XADC result path. On each end-of-conversion pulse it
// reads two XADC status registers over DRP (channel A, then channel B) and
// publishes both 12-bit codes together as analog_result = {resultB, resultA}.
// Both halves change on the same edge, so a reader never sees a mixed pair.
//
// Parameters:
//   ADDR_A  : DRP address of channel A (lands in analog_result[11:0])
//   ADDR_B  : DRP address of channel B (lands in analog_result[23:12])
//   TIMEOUT : cycles to wait for drdy after a den strobe (>= 2)
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   eoc           : end-of-conversion pulse (synchronous to HCLK)
//   drp           : DRP master port (daddr/den/dwe/di out, do_data/drdy in)
//   analog_result : {resultB, resultA}, holds between commits
//   result_valid  : 1-cycle pulse after analog_result updates
//   busy          : high whenever the sequencer is not idle
//   timeout_err   : sticky DRP timeout flag, cleared only by reset
//   sample_count  : number of committed pairs, wraps at 16 bits
// -----------------------------------------------------------------------------
module mfp_xadc_drp_reader #(
  parameter logic [6:0]  ADDR_A  = 7'h16,
  parameter logic [6:0]  ADDR_B  = 7'h1E,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          eoc,
  mfp_xadc_drp_reader_if.master         drp,
  output logic [23:0]                   analog_result,
  output logic                          result_valid,
  output logic                          busy,
  output logic                          timeout_err,
  output logic [15:0]                   sample_count
);

  // $clog2(TIMEOUT) bits always hold TIMEOUT-1, the largest value loaded.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    WAIT_A,
    RD_B,
    WAIT_B,
    COMMIT
  } state_t;

  state_t          state_reg, state_next;
  logic            pending_reg, pending_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [11:0]     tmp_a_reg, tmp_a_next;
  logic [11:0]     tmp_b_reg, tmp_b_next;
  logic [6:0]      daddr_reg, daddr_next;
  logic [23:0]     result_reg, result_next;
  logic            valid_reg, valid_next;
  logic            err_reg, err_next;
  logic [15:0]     sample_count_reg, sample_count_next;
  logic            den;

  // The low nibble of the status registers carries no conversion data.
  logic            do_low_unused;
  assign do_low_unused = ^drp.do_data[3:0];

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    pending_next      = pending_reg;
    tmo_next          = tmo_reg;
    tmp_a_next        = tmp_a_reg;
    tmp_b_next        = tmp_b_reg;
    daddr_next        = daddr_reg;
    result_next       = result_reg;
    valid_next        = 1'b0;
    err_next          = err_reg;
    sample_count_next = sample_count_reg;
    den               = 1'b0;

    // A conversion finishing while a pair is in flight is remembered once;
    // the flag is already set for any further pulses, so those are lost.
    if (eoc && (state_reg != IDLE)) begin
      pending_next = 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        if (eoc || pending_reg) begin
          pending_next = 1'b0;
          // daddr is registered, so load it on the way into the strobe cycle.
          daddr_next   = ADDR_A;
          state_next   = RD_A;
        end
      end

      RD_A: begin
        den        = 1'b1;
        tmo_next   = TMO_LOAD;
        state_next = WAIT_A;
      end

      WAIT_A: begin
        // drdy is tested before the counter so a response in the final wait
        // cycle is still accepted.
        if (drp.drdy) begin
          tmp_a_next = drp.do_data[15:4];
          daddr_next = ADDR_B;
          state_next = RD_B;
        end else if (tmo_reg == '0) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next   = tmo_reg - TW'(1);
        end
      end

      RD_B: begin
        den        = 1'b1;
        tmo_next   = TMO_LOAD;
        state_next = WAIT_B;
      end

      WAIT_B: begin
        if (drp.drdy) begin
          tmp_b_next = drp.do_data[15:4];
          state_next = COMMIT;
        end else if (tmo_reg == '0) begin
          // Abandon the whole pair; channel A's capture is simply never used.
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next   = tmo_reg - TW'(1);
        end
      end

      COMMIT: begin
        result_next       = {tmp_b_reg, tmp_a_reg};
        valid_next        = 1'b1;
        sample_count_next = sample_count_reg + 16'd1;
        state_next        = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg        <= IDLE;
      pending_reg      <= 1'b0;
      tmo_reg          <= '0;
      tmp_a_reg        <= '0;
      tmp_b_reg        <= '0;
      daddr_reg        <= '0;
      result_reg       <= '0;
      valid_reg        <= 1'b0;
      err_reg          <= 1'b0;
      sample_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      pending_reg      <= pending_next;
      tmo_reg          <= tmo_next;
      tmp_a_reg        <= tmp_a_next;
      tmp_b_reg        <= tmp_b_next;
      daddr_reg        <= daddr_next;
      result_reg       <= result_next;
      valid_reg        <= valid_next;
      err_reg          <= err_next;
      sample_count_reg <= sample_count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. den comes straight from state so it drops the moment reset hits.
  // ---------------------------------------------------------------------------
  assign drp.den       = den;
  assign drp.daddr     = daddr_reg;
  assign drp.dwe       = 1'b0;
  assign drp.di        = 16'h0000;

  assign analog_result = result_reg;
  assign result_valid  = valid_reg;
  assign busy          = (state_reg != IDLE);
  assign timeout_err   = err_reg;
  assign sample_count  = sample_count_reg;

endmodule

// File: tb/tb_mfp_xadc_drp_reader.sv
// -----------------------------------------------------------------------------
// tb_mfp_xadc_drp_reader
// Bench for mfp_xadc_drp_reader. A timeline model plans each DRP pair when it
// is triggered (strobe cycles, drdy cycles, commit or timeout cycle) and also
// acts as the DRP responder. A negedge process compares every output against
// the planned timeline each cycle; directed sections add literal checks.
// -----------------------------------------------------------------------------
module tb_mfp_xadc_drp_reader;
  localparam int TMO = 64;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        eoc     = 1'b0;
  logic [23:0] analog_result;
  logic        result_valid;
  logic        busy;
  logic        timeout_err;
  logic [15:0] sample_count;

  mfp_xadc_drp_reader_if drp_if ();

  mfp_xadc_drp_reader #(
    .ADDR_A (7'h16),
    .ADDR_B (7'h1E),
    .TIMEOUT(TMO)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .eoc          (eoc),
    .drp          (drp_if),
    .analog_result(analog_result),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .sample_count (sample_count)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Current pair plan (absolute cycle numbers, -1 = does not happen)
  int          idle_from, p_r, p_rb, p_commit, p_to, p_drdy_a, p_drdy_b;
  logic [15:0] p_da, p_db;
  bit          pending;
  // Configuration for the next pair launched
  bit          rand_mode = 1'b0;
  int          cfg_lat_a, cfg_lat_b;
  logic [15:0] cfg_da, cfg_db;
  // Expected outputs
  logic        exp_den, exp_rv, exp_busy, exp_err;
  logic [6:0]  exp_daddr;
  logic [23:0] exp_result;
  logic [15:0] exp_count;
  // Stimulus requests
  bit          eoc_req   = 1'b0;
  bit          stray_req = 1'b0;
  // Observation logs
  int          rv_log[$];
  int          den_cyc_log[$];
  logic [6:0]  den_addr_log[$];
  int          err_rise;
  int          e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pending   = 1'b0;
    p_r       = -1; p_rb = -1; p_commit = -1; p_to = -1;
    p_drdy_a  = -1; p_drdy_b = -1;
    idle_from = cyc;
    exp_den   = 1'b0; exp_rv = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
    exp_daddr = 7'h00; exp_result = 24'h0; exp_count = 16'h0;
  endtask

  task automatic pick_lat(output int k);
    int sel;
    sel = int'($urandom_range(0, 19));
    if (sel < 15)       k = int'($urandom_range(1, 8));
    else if (sel == 15) k = 0;          // never answers
    else if (sel == 16) k = TMO;        // answers in the last wait cycle
    else if (sel == 17) k = TMO + 1;    // answers one cycle too late
    else                k = int'($urandom_range(9, 30));
  endtask

  // Plan a whole pair whose RD_A strobe falls in cycle r.
  task automatic launch(input int r);
    int ka, kb;
    logic [15:0] da, db;
    if (rand_mode) begin
      pick_lat(ka); pick_lat(kb);
      da = 16'($urandom); db = 16'($urandom);
    end else begin
      ka = cfg_lat_a; kb = cfg_lat_b; da = cfg_da; db = cfg_db;
    end
    p_r = r; p_rb = -1; p_commit = -1; p_to = -1; p_drdy_a = -1; p_drdy_b = -1;
    p_da = da; p_db = db;
    if (ka >= 1 && ka <= TMO + 1) p_drdy_a = r + ka;
    if (ka >= 1 && ka <= TMO) begin
      p_rb = r + ka + 1;
      if (kb >= 1 && kb <= TMO + 1) p_drdy_b = p_rb + kb;
      if (kb >= 1 && kb <= TMO) begin
        p_commit  = p_rb + kb + 1;
        idle_from = p_commit + 1;
      end else begin
        p_to      = p_rb + TMO + 1;
        idle_from = p_to;
      end
    end else begin
      p_to      = r + TMO + 1;
      idle_from = p_to;
    end
  endtask

  // Expectations and input drive for cycle cyc, then trigger handling.
  task automatic model_cycle();
    int c;
    logic drdy_v;
    logic [15:0] data_v;
    c = cyc;
    exp_den = (c == p_r) || (c == p_rb);
    if (c == p_r)  exp_daddr = 7'h16;
    if (c == p_rb) exp_daddr = 7'h1E;
    exp_busy = (c >= p_r) && (c < idle_from);
    exp_rv   = (p_commit >= 0) && (c == p_commit + 1);
    if (exp_rv) begin
      exp_result = {p_db[15:4], p_da[15:4]};
      exp_count  = exp_count + 16'd1;
    end
    if (c == p_to) exp_err = 1'b1;

    drdy_v = (c == p_drdy_a) || (c == p_drdy_b);
    data_v = 16'($urandom);
    if (c == p_drdy_a)      data_v = p_da;
    else if (c == p_drdy_b) data_v = p_db;
    if (stray_req && c >= idle_from && !drdy_v) drdy_v = 1'b1;
    drp_if.drdy    = drdy_v;
    drp_if.do_data = data_v;
    eoc            = eoc_req;

    if (pending && c >= idle_from) begin
      pending = 1'b0;
      launch(c + 1);
    end else if (eoc_req) begin
      if (c >= idle_from) launch(c + 1);
      else                pending = 1'b1;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge HCLK);
    #1;
    cyc++;
  endtask

  task automatic settle();
    for (int i = 0; i < 400; i++) begin
      if (!pending && cyc > idle_from + 2) break;
      tick();
    end
  endtask

  task automatic pulse_eoc();
    e = cyc;
    eoc_req = 1'b1;
    tick();
    eoc_req = 1'b0;
  endtask

  task automatic cfg(input int ka, input int kb, input logic [15:0] da, input logic [15:0] db);
    cfg_lat_a = ka; cfg_lat_b = kb; cfg_da = da; cfg_db = db;
  endtask

  task automatic clear_logs();
    rv_log.delete();
    den_cyc_log.delete();
    den_addr_log.delete();
    err_rise = -1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge HCLK) begin
    if (chk_en) begin
      check("den",           32'(drp_if.den),   32'(exp_den));
      check("daddr",         32'(drp_if.daddr), 32'(exp_daddr));
      check("dwe",           32'(drp_if.dwe),   32'(0));
      check("di",            32'(drp_if.di),    32'(0));
      check("busy",          32'(busy),         32'(exp_busy));
      check("result_valid",  32'(result_valid), 32'(exp_rv));
      check("analog_result", 32'(analog_result), 32'(exp_result));
      check("sample_count",  32'(sample_count), 32'(exp_count));
      check("timeout_err",   32'(timeout_err),  32'(exp_err));
      if (drp_if.den === 1'b1) begin
        den_cyc_log.push_back(cyc);
        den_addr_log.push_back(drp_if.daddr);
      end
      if (result_valid === 1'b1) rv_log.push_back(cyc);
      if (timeout_err === 1'b1 && err_rise < 0) err_rise = cyc;
    end
  end

  initial begin
    drp_if.drdy    = 1'b0;
    drp_if.do_data = 16'h0;
    cfg(1, 1, 16'h0, 16'h0);
    model_reset();
    clear_logs();
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_den",    32'(drp_if.den),    32'(0));
    check("rst_daddr",  32'(drp_if.daddr),  32'(0));
    check("rst_busy",   32'(busy),          32'(0));
    check("rst_result", 32'(analog_result), 32'(0));
    check("rst_count",  32'(sample_count),  32'(0));
    HRESETn = 1'b1;
    cyc = 1;
    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();

    // Single pair, 1-cycle DRP latency
    clear_logs();
    cfg(1, 1, 16'hABC0, 16'h1230);
    pulse_eoc();
    settle();
    check("t1_den_a_addr", 32'(den_addr_log[0]), 32'(7'h16));
    check("t1_den_b_addr", 32'(den_addr_log[1]), 32'(7'h1E));
    check("t1_den_a_cyc",  32'(den_cyc_log[0] - e), 32'(1));
    check("t1_rv_latency", 32'(rv_log[0] - e), 32'(6));
    check("t1_result",     32'(analog_result), 32'(24'h123ABC));
    check("t1_count",      32'(sample_count), 32'(1));

    // Slow DRP: 5 cycles for A, 7 for B
    clear_logs();
    cfg(5, 7, 16'h1111, 16'h2222);
    pulse_eoc();
    settle();
    check("t2_den_count",  32'(den_cyc_log.size()), 32'(2));
    check("t2_rv_latency", 32'(rv_log[0] - e), 32'(16));
    check("t2_result",     32'(analog_result), 32'(24'h222111));

    // Two extra eoc pulses while busy: one is queued, one dropped
    clear_logs();
    cfg(1, 1, 16'hABC0, 16'h1230);
    e = cyc;
    eoc_req = 1'b1;
    repeat (3) tick();
    eoc_req = 1'b0;
    settle();
    check("t3_commits",    32'(rv_log.size()), 32'(2));
    check("t3_rv_spacing", 32'(rv_log[1] - rv_log[0]), 32'(6));
    check("t3_second_rda", 32'(den_cyc_log[2] - (rv_log[0] - 1)), 32'(2));
    check("t3_count",      32'(sample_count), 32'(4));

    // B never answers
    clear_logs();
    cfg(1, 0, 16'h5550, 16'h0000);
    pulse_eoc();
    settle();
    // Set on the 64th edge after the B strobe, visible the cycle after.
    check("t4_err_delay",  32'(err_rise - den_cyc_log[1]), 32'(65));
    check("t4_no_rv",      32'(rv_log.size()), 32'(0));
    check("t4_result_kept", 32'(analog_result), 32'(24'h123ABC));
    check("t4_busy",       32'(busy), 32'(0));
    clear_logs();
    cfg(1, 1, 16'h0010, 16'hFFF0);
    pulse_eoc();
    settle();
    check("t4_recover_result", 32'(analog_result), 32'(24'hFFF001));
    check("t4_err_sticky",     32'(timeout_err), 32'(1));
    check("t4_count",          32'(sample_count), 32'(5));

    // Timeout boundary on A: last wait cycle accepted, one later is not
    clear_logs();
    cfg(TMO, 1, 16'h7770, 16'h8880);
    pulse_eoc();
    settle();
    check("t5_last_cycle_result", 32'(analog_result), 32'(24'h888777));
    check("t5_last_cycle_count",  32'(sample_count), 32'(6));
    clear_logs();
    cfg(TMO + 1, 1, 16'h9990, 16'hAAA0);
    pulse_eoc();
    settle();
    check("t5_late_no_rv",  32'(rv_log.size()), 32'(0));
    check("t5_late_result", 32'(analog_result), 32'(24'h888777));

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      eoc_req   = ($urandom_range(0, 5) == 0);
      stray_req = ($urandom_range(0, 7) == 0);
      tick();
    end
    eoc_req   = 1'b0;
    stray_req = 1'b0;
    rand_mode = 1'b0;
    settle();

    // Reset during WAIT_B
    cfg(1, 30, 16'h4440, 16'h3330);
    pulse_eoc();
    repeat (5) tick();
    chk_en = 1'b0;
    drp_if.drdy = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_den",    32'(drp_if.den),    32'(0));
    check("t6_daddr",  32'(drp_if.daddr),  32'(0));
    check("t6_busy",   32'(busy),          32'(0));
    check("t6_rv",     32'(result_valid),  32'(0));
    check("t6_result", 32'(analog_result), 32'(0));
    check("t6_err",    32'(timeout_err),   32'(0));
    check("t6_count",  32'(sample_count),  32'(0));
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    cyc += 2;
    HRESETn = 1'b1;
    model_reset();
    chk_en = 1'b1;
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    tick();
    clear_logs();
    cfg(1, 1, 16'hC0D0, 16'hE0F0);
    pulse_eoc();
    settle();
    check("t6_clean_result", 32'(analog_result), 32'(24'hE0FC0D));
    check("t6_clean_count",  32'(sample_count), 32'(1));

    // Counter wrap: preload the count, then commit once more
    force dut.sample_count_reg = 16'hFFFF;
    #1;
    release dut.sample_count_reg;
    exp_count = 16'hFFFF;
    clear_logs();
    cfg(1, 1, 16'h0120, 16'h0340);
    pulse_eoc();
    settle();
    check("t7_wrap_count",  32'(sample_count), 32'(0));
    check("t7_wrap_rv",     32'(rv_log.size()), 32'(1));
    check("t7_wrap_result", 32'(analog_result), 32'(24'h034012));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
